// File: rtl/mult_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : mult_accum_stage
// Brief    : Sums a programmed-length block of unsigned multiplier products
//            into an accumulator and returns the sum over a valid/ready
//            handshake. Optional saturation via MULT_ACC_SATURATE_EN.
//            Default build (macro undefined): the sum wraps modulo 2^ACC_W
//            and res_ovf flags the carry.
// Revision : 1.0 - initial release
// ============================================================================
module mult_accum_stage #(
  parameter int PROD_W = 16,  // product width from the multiplier
  parameter int ACC_W  = 24,  // accumulator width, expected >= PROD_W
  parameter int LEN_W  = 8    // block-length field width
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;

  // One extra bit on the adder exposes the carry out of the accumulator.
  logic [ACC_W:0]     w_prod_ext;
  logic [ACC_W:0]     w_sum;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_next;
  logic [LEN_W-1:0]   w_count_inc;

  assign w_prod_ext  = (ACC_W+1)'(prod_data);
  assign w_sum       = {1'b0, acc_q} + w_prod_ext;
  assign w_carry     = w_sum[ACC_W];
  assign w_count_inc = count_q + LEN_W'(1);

`ifdef MULT_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] c_acc_ones = '1;
  // Clamp to all ones on carry; once clamped, further adds keep it there.
  assign w_acc_next = w_carry ? c_acc_ones : w_sum[ACC_W-1:0];
`else
  // Plain modulo-2^ACC_W wrap.
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  // Outputs come from registers or state decode only, never from inputs.
  assign prod_ready = (state_q == ST_ACCUM);
  assign res_valid  = (state_q == ST_DONE);
  assign res_data   = acc_q;
  assign res_ovf    = ovf_q;
  assign busy       = (state_q != ST_IDLE);

  // Next-state and datapath update for the block sequencer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          len_d   = cfg_len;
          // An empty block goes straight to the result with a zero sum.
          state_d = (cfg_len != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        if (prod_valid) begin
          acc_d   = w_acc_next;
          ovf_d   = ovf_q | w_carry;
          count_d = w_count_inc;
          if (w_count_inc == len_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_accum_stage
// Brief    : Directed self-checking bench for mult_accum_stage. A second
//            instance with ACC_W=16 exercises the overflow behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_accum_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_len;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] prod_data;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_data;
  logic        res_ovf;
  logic        busy;

  logic        s_start;
  logic [7:0]  s_cfg_len;
  logic        s_prod_valid;
  logic        s_prod_ready;
  logic [15:0] s_prod_data;
  logic        s_res_valid;
  logic        s_res_ready;
  logic [15:0] s_res_data;
  logic        s_res_ovf;
  logic        s_busy;

  int passed = 0;
  int total  = 0;
  int beats  = 0;

  mult_accum_stage u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_len    (cfg_len),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_ovf    (res_ovf),
    .busy       (busy)
  );

  mult_accum_stage #(.PROD_W(16), .ACC_W(16), .LEN_W(8)) u_dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s_start),
    .cfg_len    (s_cfg_len),
    .prod_valid (s_prod_valid),
    .prod_ready (s_prod_ready),
    .prod_data  (s_prod_data),
    .res_valid  (s_res_valid),
    .res_ready  (s_res_ready),
    .res_data   (s_res_data),
    .res_ovf    (s_res_ovf),
    .busy       (s_busy)
  );

  always #5 clk = ~clk;

  // Count accepted product beats on the main instance.
  always @(posedge clk) begin
    if (prod_valid && prod_ready) beats <= beats + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [7:0] len);
    start   = 1'b1;
    cfg_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d);
    prod_valid = 1'b1;
    prod_data  = d;
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic finish_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (prod_ready !== 1'b0) $display("FAIL reset_prod_ready: got %b want 0", prod_ready); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else passed++;
    total++; if (res_data !== 24'h0) $display("FAIL reset_res_data: got %h want 000000", res_data); else passed++;
    total++; if (res_ovf !== 1'b0) $display("FAIL reset_res_ovf: got %b want 0", res_ovf); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    // Abort a 5-beat block after three beats.
    start_block(8'd5);
    send_beat(16'h0001);
    send_beat(16'h0002);
    send_beat(16'h0003);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    total++; if (prod_ready !== 1'b0) $display("FAIL abort_prod_ready: got %b want 0", prod_ready); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL abort_res_valid: got %b want 0", res_valid); else passed++;
    total++; if (res_data !== 24'h0) $display("FAIL abort_res_data: got %h want 000000", res_data); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_block(8'd2);
    send_beat(16'h0010);
    send_beat(16'h0020);
    total++; if (res_valid !== 1'b1) $display("FAIL fresh_res_valid: got %b want 1", res_valid); else passed++;
    total++; if (res_data !== 24'h000030) $display("FAIL fresh_res_data: got %h want 000030", res_data); else passed++;
    total++; if (res_ovf !== 1'b0) $display("FAIL fresh_res_ovf: got %b want 0", res_ovf); else passed++;
    finish_result();
    total++; if (res_valid !== 1'b0) $display("FAIL fresh_valid_drop: got %b want 0", res_valid); else passed++;
  endtask

  task automatic test_toggle_valid();
    int b0;
    b0 = beats;
    start_block(8'd4);
    for (int i = 0; i < 8; i++) begin
      prod_valid = (i % 2 == 0);
      prod_data  = (i % 2 == 0) ? 16'hFE01 : 16'hFFFF;
      tick();
    end
    prod_valid = 1'b0;
    total++; if (res_valid !== 1'b1) $display("FAIL toggle_res_valid: got %b want 1", res_valid); else passed++;
    total++; if (res_data !== 24'h03F804) $display("FAIL toggle_res_data: got %h want 03f804", res_data); else passed++;
    total++; if (res_ovf !== 1'b0) $display("FAIL toggle_res_ovf: got %b want 0", res_ovf); else passed++;
    total++; if (beats - b0 !== 4) $display("FAIL toggle_beats: got %0d want 4", beats - b0); else passed++;
    finish_result();
  endtask

  task automatic test_zero_len();
    int b0;
    b0 = beats;
    prod_valid = 1'b1;
    prod_data  = 16'h1111;
    start_block(8'd0);
    total++; if (res_valid !== 1'b1) $display("FAIL zero_res_valid: got %b want 1", res_valid); else passed++;
    total++; if (res_data !== 24'h0) $display("FAIL zero_res_data: got %h want 000000", res_data); else passed++;
    total++; if (prod_ready !== 1'b0) $display("FAIL zero_prod_ready: got %b want 0", prod_ready); else passed++;
    finish_result();
    prod_valid = 1'b0;
    total++; if (beats - b0 !== 0) $display("FAIL zero_beats: got %0d want 0", beats - b0); else passed++;
  endtask

  task automatic test_hold_and_back_to_back();
    start_block(8'd1);
    send_beat(16'h1234);
    for (int i = 0; i < 5; i++) begin
      start   = 1'b1;
      cfg_len = 8'd3;
      tick();
      total++; if (res_data !== 24'h001234) $display("FAIL hold_res_data[%0d]: got %h want 001234", i, res_data); else passed++;
      total++; if (prod_ready !== 1'b0) $display("FAIL hold_prod_ready[%0d]: got %b want 0", i, prod_ready); else passed++;
      total++; if (res_valid !== 1'b1) $display("FAIL hold_res_valid[%0d]: got %b want 1", i, res_valid); else passed++;
    end
    start = 1'b0;
    finish_result();
    total++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy: got %b want 0", busy); else passed++;
    start_block(8'd1);
    total++; if (prod_ready !== 1'b1) $display("FAIL b2b_prod_ready: got %b want 1", prod_ready); else passed++;
    send_beat(16'h0001);
    total++; if (res_data !== 24'h000001) $display("FAIL b2b_res_data: got %h want 000001", res_data); else passed++;
    finish_result();
  endtask

  task automatic test_overflow();
    logic [15:0] exp_data;
`ifdef MULT_ACC_SATURATE_EN
    exp_data = 16'hFFFF;
`else
    exp_data = 16'h0001;
`endif
    s_start = 1'b1; s_cfg_len = 8'd2; tick(); s_start = 1'b0;
    s_prod_valid = 1'b1;
    s_prod_data = 16'hFFFF; tick();
    s_prod_data = 16'h0002; tick();
    s_prod_valid = 1'b0;
    total++; if (s_res_valid !== 1'b1) $display("FAIL ovf_res_valid: got %b want 1", s_res_valid); else passed++;
    total++; if (s_res_data !== exp_data) $display("FAIL ovf_res_data: got %h want %h", s_res_data, exp_data); else passed++;
    total++; if (s_res_ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", s_res_ovf); else passed++;
    s_res_ready = 1'b1; tick(); s_res_ready = 1'b0;
    // A new start clears the sticky flag.
    s_start = 1'b1; s_cfg_len = 8'd1; tick(); s_start = 1'b0;
    s_prod_valid = 1'b1; s_prod_data = 16'h0005; tick(); s_prod_valid = 1'b0;
    total++; if (s_res_data !== 16'h0005) $display("FAIL ovf_next_data: got %h want 0005", s_res_data); else passed++;
    total++; if (s_res_ovf !== 1'b0) $display("FAIL ovf_next_flag: got %b want 0", s_res_ovf); else passed++;
    s_res_ready = 1'b1; tick(); s_res_ready = 1'b0;
  endtask

  task automatic test_max_len();
    int b0;
    int early;
    b0 = beats;
    early = 0;
    start_block(8'd255);
    prod_valid = 1'b1;
    prod_data  = 16'hFE01;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (i < 254 && res_valid) early++;
    end
    prod_valid = 1'b0;
    total++; if (early !== 0) $display("FAIL max_early_valid: got %0d want 0", early); else passed++;
    total++; if (res_valid !== 1'b1) $display("FAIL max_res_valid: got %b want 1", res_valid); else passed++;
    total++; if (res_data !== 24'hFD02FF) $display("FAIL max_res_data: got %h want fd02ff", res_data); else passed++;
    total++; if (res_ovf !== 1'b0) $display("FAIL max_res_ovf: got %b want 0", res_ovf); else passed++;
    total++; if (beats - b0 !== 255) $display("FAIL max_beats: got %0d want 255", beats - b0); else passed++;
    finish_result();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; cfg_len = 8'd0; prod_valid = 1'b0; prod_data = 16'h0; res_ready = 1'b0;
    s_start = 1'b0; s_cfg_len = 8'd0; s_prod_valid = 1'b0; s_prod_data = 16'h0; s_res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_toggle_valid();
    test_zero_len();
    test_hold_and_back_to_back();
    test_overflow();
    test_max_len();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
